// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the 2-way write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_RESPOND   = 3'd4
  } cache_state_t;

  // Tags are stored zero-extended to a fixed width so the meta struct is geometry-independent.
  localparam int TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
  } line_meta_t;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_bytes, input int sets);
    return addr_w - $clog2(sets) - $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/cache_way_store.sv
// One cache way: line data plus valid/dirty/tag meta per set, read by index,
// written either as a whole fill line (clean) or as a single merged byte (dirty).
module cache_way_store
  import cache_pkg::*;
#(
  parameter int LINE_BYTES = 4,
  parameter int SETS       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [idx_w(SETS)-1:0]        idx,
  output logic [LINE_BYTES*8-1:0]       rd_line,
  output line_meta_t                    rd_meta,
  input  logic                          fill_en,
  input  logic [LINE_BYTES*8-1:0]       fill_line,
  input  logic [TAG_MAX_W-1:0]          fill_tag,
  input  logic                          byte_en,
  input  logic [off_w(LINE_BYTES)-1:0]  byte_off,
  input  logic [7:0]                    byte_data
);

  localparam int LW = LINE_BYTES * 8;

  logic [LW-1:0] data_q [SETS];
  logic [LW-1:0] data_d [SETS];
  line_meta_t    meta_q [SETS];
  line_meta_t    meta_d [SETS];

  assign rd_line = data_q[idx];
  assign rd_meta = meta_q[idx];

  // Next contents: a fill takes priority over a byte merge.
  always_comb begin
    data_d = data_q;
    meta_d = meta_q;
    if (fill_en) begin
      data_d[idx] = fill_line;
      meta_d[idx] = '{valid: 1'b1, dirty: 1'b0, tag: fill_tag};
    end else if (byte_en) begin
      data_d[idx][{byte_off, 3'b000} +: 8] = byte_data;
      meta_d[idx].dirty = 1'b1;
    end else begin
      data_d[idx] = data_q[idx];
    end
  end

  // Only meta is cleared on reset; stale data is unreachable once valid drops.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        meta_q[i] <= '0;
      end
    end else begin
      meta_q <= meta_d;
    end
  end

endmodule

// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back, write-allocate cache with per-set LRU.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_2way_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int LINE_BYTES = 4,
  parameter int SETS       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_read_req,
  input  logic                     proc_write_req,
  input  logic [ADDR_W-1:0]        proc_address,
  input  logic [7:0]               proc_write_data,
  output logic [LINE_BYTES*8-1:0]  cache_read_data,
  output logic                     cache_read_ready,
  output logic                     cache_write_ready,
  output logic                     mem_read_req,
  output logic                     mem_write_req,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LINE_BYTES*8-1:0]  mem_write_data,
  input  logic [LINE_BYTES*8-1:0]  mem_read_data,
  input  logic                     mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]              stat_hits,
  output logic [15:0]              stat_misses
`endif
);

  localparam int OFF_W = off_w(LINE_BYTES);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, LINE_BYTES, SETS);
  localparam int LW    = LINE_BYTES * 8;

  cache_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic              victim_q, victim_d;
  logic [SETS-1:0]   lru_q, lru_d;
  logic [LW-1:0]     rdata_q, rdata_d;
  logic              rready_q, rready_d;
  logic              wready_q, wready_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [LW-1:0]     mwdata_q, mwdata_d;

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [OFF_W-1:0]  off_s;
  logic [LW-1:0]     way_line [2];
  line_meta_t        way_meta [2];
  logic [1:0]        hit_s;
  logic              hit_way_s;
  logic              vict_s;
  logic [1:0]        fill_en_s;
  logic [1:0]        byte_en_s;
  logic [ADDR_W-1:0] fill_addr_s;
  logic [ADDR_W-1:0] wb_addr_s;

  assign idx_s = addr_q[OFF_W +: IDX_W];
  assign tag_s = addr_q[ADDR_W-1 -: TAG_W];
  assign off_s = addr_q[OFF_W-1:0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way_store #(.LINE_BYTES(LINE_BYTES), .SETS(SETS)) u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx_s),
      .rd_line   (way_line[w]),
      .rd_meta   (way_meta[w]),
      .fill_en   (fill_en_s[w]),
      .fill_line (mem_read_data),
      .fill_tag  (TAG_MAX_W'(tag_s)),
      .byte_en   (byte_en_s[w]),
      .byte_off  (off_s),
      .byte_data (wdata_q)
    );
    assign hit_s[w] = way_meta[w].valid && (way_meta[w].tag == TAG_MAX_W'(tag_s));
  end

  // lru_q[set] names the least-recently-used way; invalid ways are preferred victims.
  assign hit_way_s   = hit_s[1];
  assign vict_s      = !way_meta[0].valid ? 1'b0 :
                       (!way_meta[1].valid ? 1'b1 : lru_q[idx_s]);
  assign fill_addr_s = {tag_s, idx_s, {OFF_W{1'b0}}};
  assign wb_addr_s   = {way_meta[vict_s].tag[TAG_W-1:0], idx_s, {OFF_W{1'b0}}};

  // Controller next-state and registered output values.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    victim_d   = victim_q;
    lru_d      = lru_q;
    rdata_d    = rdata_q;
    rready_d   = 1'b0;
    wready_d   = 1'b0;
    mrd_d      = mrd_q;
    mwr_d      = mwr_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    fill_en_s  = 2'b00;
    byte_en_s  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (proc_write_req || proc_read_req) begin
          addr_d     = proc_address;
          wdata_d    = proc_write_data;
          is_write_d = proc_write_req;
          state_d    = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (|hit_s) begin
          lru_d[idx_s] = ~hit_way_s;
          if (is_write_q) begin
            byte_en_s[hit_way_s] = 1'b1;
            wready_d             = 1'b1;
          end else begin
            rdata_d  = way_line[hit_way_s];
            rready_d = 1'b1;
          end
          state_d = S_RESPOND;
        end else begin
          victim_d = vict_s;
          if (way_meta[vict_s].valid && way_meta[vict_s].dirty) begin
            mwr_d    = 1'b1;
            maddr_d  = wb_addr_s;
            mwdata_d = way_line[vict_s];
            state_d  = S_WRITEBACK;
          end else begin
            mrd_d   = 1'b1;
            maddr_d = fill_addr_s;
            state_d = S_FILL;
          end
        end
      end
      S_WRITEBACK: begin
        if (mem_ready) begin
          mwr_d   = 1'b0;
          mrd_d   = 1'b1;
          maddr_d = fill_addr_s;
          state_d = S_FILL;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          mrd_d               = 1'b0;
          fill_en_s[victim_q] = 1'b1;
          state_d             = S_LOOKUP;
        end else begin
          state_d = S_FILL;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      is_write_q <= 1'b0;
      victim_q   <= 1'b0;
      lru_q      <= '0;
      rdata_q    <= '0;
      rready_q   <= 1'b0;
      wready_q   <= 1'b0;
      mrd_q      <= 1'b0;
      mwr_q      <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      victim_q   <= victim_d;
      lru_q      <= lru_d;
      rdata_q    <= rdata_d;
      rready_q   <= rready_d;
      wready_q   <= wready_d;
      mrd_q      <= mrd_d;
      mwr_q      <= mwr_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
    end
  end

  assign cache_read_data   = rdata_q;
  assign cache_read_ready  = rready_q;
  assign cache_write_ready = wready_q;
  assign mem_read_req      = mrd_q;
  assign mem_write_req     = mwr_q;
  assign mem_address       = maddr_q;
  assign mem_write_data    = mwdata_q;

`ifdef CACHE_STATS_EN
  logic        first_q, first_d;
  logic [15:0] hits_q, hits_d;
  logic [15:0] misses_q, misses_d;

  // first_q marks the first LOOKUP of a request so the post-fill replay is not counted.
  always_comb begin
    first_d  = first_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == S_IDLE) begin
      first_d = proc_write_req || proc_read_req;
    end else if (state_q == S_LOOKUP) begin
      first_d = 1'b0;
      if (first_q && (|hit_s) && (hits_q != 16'hFFFF)) begin
        hits_d = hits_q + 16'd1;
      end else if (first_q && !(|hit_s) && (misses_q != 16'hFFFF)) begin
        misses_d = misses_q + 16'd1;
      end else begin
        hits_d = hits_q;
      end
    end else begin
      first_d = first_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q  <= 1'b0;
      hits_q   <= 16'd0;
      misses_q <= 16'd0;
    end else begin
      first_q  <= first_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_cache_2way_wb.sv
// Scoreboard bench for cache_2way_wb: a flat memory image predicts read data and
// expected processor responses and memory transactions are queued then popped.
module tb_cache_2way_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        proc_read_req, proc_write_req;
  logic [9:0]  proc_address;
  logic [7:0]  proc_write_data;
  logic [31:0] cache_read_data;
  logic        cache_read_ready, cache_write_ready;
  logic        mem_read_req, mem_write_req;
  logic [9:0]  mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] stat_hits, stat_misses;
`endif

  cache_2way_wb #(.ADDR_W(10), .LINE_BYTES(4), .SETS(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .proc_read_req     (proc_read_req),
    .proc_write_req    (proc_write_req),
    .proc_address      (proc_address),
    .proc_write_data   (proc_write_data),
    .cache_read_data   (cache_read_data),
    .cache_read_ready  (cache_read_ready),
    .cache_write_ready (cache_write_ready),
    .mem_read_req      (mem_read_req),
    .mem_write_req     (mem_write_req),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .mem_ready         (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits         (stat_hits),
    .stat_misses       (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic        is_wr;
    logic [9:0]  addr;
    logic [31:0] data;
  } mem_op_t;

  resp_t       resp_q[$];
  mem_op_t     mem_q[$];
  logic [31:0] backing [256];
  logic [31:0] model_line [256];
  int          n_checks = 0;
  int          n_errors = 0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  logic [9:0]  first_addr;
  logic        first_rd;
  int          exp_hits = 0;
  int          exp_misses = 0;
  resp_t       mon_r;
  mem_op_t     mem_op;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero();
    check_eq("rst_read_data", cache_read_data, 0);
    check_eq("rst_read_ready", cache_read_ready, 0);
    check_eq("rst_write_ready", cache_write_ready, 0);
    check_eq("rst_mem_read_req", mem_read_req, 0);
    check_eq("rst_mem_write_req", mem_write_req, 0);
    check_eq("rst_mem_address", mem_address, 0);
    check_eq("rst_mem_write_data", mem_write_data, 0);
  endtask

  task automatic push_mem(input logic is_wr, input logic [9:0] addr, input logic [31:0] data);
    mem_op_t m;
    m.is_wr = is_wr;
    m.addr  = addr;
    m.data  = data;
    mem_q.push_back(m);
  endtask

  // One processor request; latency counted in cycles after the accepting edge.
  task automatic issue(input logic wr, input logic rd, input logic [9:0] a, input logic [7:0] d,
                       input logic exp_hit, input int exp_lat);
    resp_t r;
    int    cyc;
    if (wr) begin
      model_line[a[9:2]][{a[1:0], 3'b000} +: 8] = d;
      r.is_wr = 1'b1;
      r.data  = 32'h0;
    end else begin
      r.is_wr = 1'b0;
      r.data  = model_line[a[9:2]];
    end
    resp_q.push_back(r);
    if (exp_hit) exp_hits++;
    else exp_misses++;
    @(negedge clk);
    proc_write_req  = wr;
    proc_read_req   = rd;
    proc_address    = a;
    proc_write_data = d;
    @(posedge clk);
    @(negedge clk);
    proc_write_req = 1'b0;
    proc_read_req  = 1'b0;
    cyc = 1;
    while (!(cache_read_ready || cache_write_ready) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check_eq("resp_timeout", 0, 1);
    else check_eq("latency", cyc, exp_lat);
  endtask

  // Response scoreboard.
  always @(negedge clk) begin
    if (!rst && (cache_read_ready || cache_write_ready)) begin
      if (resp_q.size() == 0) begin
        check_eq("resp_unexpected", 1, 0);
      end else begin
        mon_r = resp_q.pop_front();
        check_eq("resp_excl", cache_read_ready & cache_write_ready, 0);
        check_eq("resp_kind", cache_write_ready, mon_r.is_wr);
        if (!mon_r.is_wr) check_eq("read_data", cache_read_data, mon_r.data);
      end
    end
  end

  // Backing memory: mem_delay idle cycles then a one-cycle mem_ready.
  initial begin
    mem_ready     = 1'b0;
    mem_read_data = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (mem_read_req || mem_write_req) begin
        check_eq("mem_excl", mem_read_req & mem_write_req, 0);
        if (wait_cnt == 0) begin
          first_addr = mem_address;
          first_rd   = mem_read_req;
        end else begin
          check_eq("mem_addr_stable", mem_address, first_addr);
          check_eq("mem_req_stable", mem_read_req, first_rd);
        end
        if (wait_cnt < mem_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt  = 0;
          mem_ready = 1'b1;
          if (mem_q.size() == 0) begin
            check_eq("mem_unexpected", {mem_write_req, mem_address}, 0);
          end else begin
            mem_op = mem_q.pop_front();
            check_eq("mem_kind", mem_write_req, mem_op.is_wr);
            check_eq("mem_addr", mem_address, mem_op.addr);
            if (mem_op.is_wr) check_eq("mem_wdata", mem_write_data, mem_op.data);
          end
          if (mem_write_req) backing[mem_address[9:2]] = mem_write_data;
          else mem_read_data = backing[mem_address[9:2]];
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      backing[i]    = 32'h44332211 + 32'h01010101 * i;
      model_line[i] = backing[i];
    end
    rst = 1'b1;
    proc_read_req = 1'b0;
    proc_write_req = 1'b0;
    proc_address = 10'h0;
    proc_write_data = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero();
    rst = 1'b0;

    // Write miss then read hit of the merged line.
    push_mem(1'b0, 10'h000, 32'h0);
    issue(1'b1, 1'b0, 10'h001, 8'hFF, 1'b0, 4);
    issue(1'b0, 1'b1, 10'h001, 8'h00, 1'b1, 2);
    check_eq("merged_line", cache_read_data, 32'h4433FF11);

    // Fill second way, then evict dirty way 0.
    push_mem(1'b0, 10'h040, 32'h0);
    issue(1'b0, 1'b1, 10'h041, 8'h00, 1'b0, 4);
    push_mem(1'b1, 10'h000, model_line[0]);
    push_mem(1'b0, 10'h080, 32'h0);
    issue(1'b0, 1'b1, 10'h081, 8'h00, 1'b0, 5);
    issue(1'b0, 1'b1, 10'h041, 8'h00, 1'b1, 2);

    // Slow fill.
    mem_delay = 5;
    push_mem(1'b0, 10'h0C0, 32'h0);
    issue(1'b0, 1'b1, 10'h0C1, 8'h00, 1'b0, 9);
    check_eq("read_data_hold", cache_read_data, model_line[8'h30]);

    // Reset during a fill.
    mem_delay = 20;
    @(negedge clk);
    proc_read_req = 1'b1;
    proc_address  = 10'h101;
    @(posedge clk);
    @(negedge clk);
    proc_read_req = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("fill_req", mem_read_req, 1);
    check_eq("fill_addr", mem_address, 10'h100);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero();
    rst = 1'b0;
    mem_delay = 0;
    exp_hits = 0;
    exp_misses = 0;
    push_mem(1'b0, 10'h000, 32'h0);
    issue(1'b0, 1'b1, 10'h001, 8'h00, 1'b0, 4);

    // Both requests: write wins.
    issue(1'b1, 1'b1, 10'h001, 8'h5A, 1'b1, 2);
    issue(1'b0, 1'b1, 10'h001, 8'h00, 1'b1, 2);

    repeat (3) @(negedge clk);
    check_eq("resp_q_empty", resp_q.size(), 0);
    check_eq("mem_q_empty", mem_q.size(), 0);
`ifdef CACHE_STATS_EN
    check_eq("stat_hits", stat_hits, exp_hits);
    check_eq("stat_misses", stat_misses, exp_misses);
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
